data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
// - Memory-side responder for the core's load/store port (addr, read_enable, write_enable, mem_done).
// - Serves one word per request from an internal synchronous RAM after a programmable number of wait states.
// - Signals completion with a one-cycle mem_done pulse; the core holds its PC and enables until that pulse.
// - Flags misaligned, out-of-range and illegal (read+write) requests on mem_err instead of touching RAM.
// PARAMETERS
// - DEPTH_WORDS  256  number of 32-bit words; power of two, >= 2
// - WAIT_STATES  2    cycles spent in WAIT between acceptance and DONE; 0 is legal
// - BASE_ADDR    0    byte address of word 0; must be a multiple of 4*DEPTH_WORDS
// - INIT_FILE    ""   optional $readmemh image; if empty, RAM contents are undefined at power-up
// PORTS
// - clk           in   1   clock, rising edge
// - rst           in   1   reset, synchronous, active-high
// - addr          in   32  byte address of the request
// - wdata         in   32  store data
// - read_enable   in   1   load request, level, held by core until mem_done
// - write_enable  in   1   store request, level, held by core until mem_done
// - rdata         out  32  load data, valid in the mem_done cycle
// - mem_done      out  1   one-cycle completion pulse
// - mem_err       out  1   error qualifier, valid only while mem_done=1
// - busy          out  1   high in WAIT and DONE
// BEHAVIOUR
// - Reset: state=IDLE, rdata=0, mem_done=0, mem_err=0, busy=0, wait counter=0. RAM contents are NOT cleared.
// - req = read_enable | write_enable. Each IDLE->ACCEPT is a new request; a level still high in the cycle after DONE is the next instruction's request.
// - FSM IDLE: on req, latch addr/wdata/read/write into request regs, counter=WAIT_STATES; go WAIT if WAIT_STATES>0, else DONE.
// - FSM WAIT: counter decrements each cycle; at counter==1 go DONE. If req drops while in WAIT: abort to IDLE, no pulse, no RAM write.
// - FSM DONE: mem_done=1 for exactly one cycle, then IDLE unconditionally (DONE is not abortable).
// - Latency: request first visible in cycle 0 -> mem_done high in cycle 1+WAIT_STATES. Back-to-back requests: next mem_done no earlier than 2+WAIT_STATES cycles later.
// - Error check on latched request: addr[1:0]!=0, or (addr-BASE_ADDR)>>2 >= DEPTH_WORDS, or read&write both set -> mem_err=1 in DONE, rdata=0, RAM unchanged.
// - Load: RAM read using word index (addr-BASE_ADDR)>>2 registered so rdata is stable throughout the DONE cycle; rdata holds its last value outside DONE.
// - Store: RAM written with latched wdata on the clock edge that ends DONE (same edge the core advances PC); rdata unchanged by a store.
// - Read-after-write to the same word in consecutive requests returns the new data.
// - Inputs changing in WAIT/DONE are ignored (only request regs are used), except the req-drop abort rule.
// - Reset mid-operation: request discarded, pending store never committed, outputs return to reset values next cycle.
// - Counter width $clog2(WAIT_STATES+1) (min 1); word index width $clog2(DEPTH_WORDS); address subtract is 32-bit unsigned, wrap below BASE_ADDR counts as out-of-range.
// TESTING
// - WAIT_STATES=2, store addr=0x10 wdata=0xDEADBEEF -> mem_done pulses cycle 3, mem_err=0; then load 0x10 -> rdata=0xDEADBEEF with mem_done.
// - WAIT_STATES=0, back-to-back loads 0x0,0x4 held continuously -> two distinct 1-cycle mem_done pulses at cycles 1 and 3, correct data each.
// - Load addr=0x12 (misaligned) -> mem_done+mem_err=1, rdata=0; store addr=0x400 (DEPTH 256) -> mem_err=1, RAM unchanged.
// - read_enable and write_enable both high addr=0x8 -> mem_err=1, word 0x8 readback unchanged.
// - Store 0x20 data 0x12345678, drop write_enable in WAIT -> no mem_done, later load 0x20 returns prior value.
// - Assert rst during WAIT of a store -> mem_done never pulses, busy=0 next cycle, stored word unchanged.

Source files
------------

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core load/store port: one word per request from an internal RAM.
// Latency 1+WAIT_STATES cycles to the mem_done pulse; the core holds its request level until then (dropping it in WAIT aborts).
module data_mem_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter              INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        read_enable,
    input  logic        write_enable,
    output logic [31:0] rdata,
    output logic        mem_done,
    output logic        mem_err,
    output logic        busy
);
    localparam int IDXW = $clog2(DEPTH_WORDS);
    localparam int CW   = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t            state, next_state;
    logic [CW-1:0]     cnt;
    logic [31:0]       ram [DEPTH_WORDS];

    logic              req;
    logic [31:0]       in_off;
    logic [IDXW-1:0]   in_idx;
    logic              in_err;

    logic [IDXW-1:0]   req_idx;
    logic              req_err;
    logic              req_rd;
    logic              req_wr;
    logic [31:0]       req_wdata;

    logic [IDXW-1:0]   cur_idx;
    logic              cur_err;
    logic              cur_rd;
    logic              enter_done;

    assign req = read_enable | write_enable;

    // Wrap below BASE_ADDR lands in the high bits and is caught as out-of-range.
    always_comb begin
        in_off = addr - BASE_ADDR;
        in_idx = in_off[IDXW+1:2];
        in_err = (in_off[1:0] != 2'b00) || (|in_off[31:IDXW+2]) || (read_enable && write_enable);
    end

    // With zero wait states DONE is entered straight from IDLE, before the request regs are loaded.
    always_comb begin
        cur_idx    = (state == S_IDLE) ? in_idx      : req_idx;
        cur_err    = (state == S_IDLE) ? in_err      : req_err;
        cur_rd     = (state == S_IDLE) ? read_enable : req_rd;
        enter_done = (next_state == S_DONE) && (state != S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (req) next_state = (WAIT_STATES > 0) ? S_WAIT : S_DONE;
            S_WAIT: begin
                if (!req)               next_state = S_IDLE;
                else if (cnt == CW'(1)) next_state = S_DONE;
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        mem_done = (state == S_DONE);
        mem_err  = (state == S_DONE) && req_err;
        busy     = (state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            req_idx   <= '0;
            req_err   <= 1'b0;
            req_rd    <= 1'b0;
            req_wr    <= 1'b0;
            req_wdata <= '0;
        end else if (state == S_IDLE && req) begin
            cnt       <= CW'(WAIT_STATES);
            req_idx   <= in_idx;
            req_err   <= in_err;
            req_rd    <= read_enable;
            req_wr    <= write_enable;
            req_wdata <= wdata;
        end else if (state == S_WAIT) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Read is registered on the edge entering DONE so rdata is stable for the whole pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (enter_done) begin
            if (cur_err)     rdata <= '0;
            else if (cur_rd) rdata <= ram[cur_idx];
        end
    end

    // Store commits on the edge that ends DONE, the same edge the core advances on.
    always_ff @(posedge clk) begin
        if (!rst && state == S_DONE && req_wr && !req_err) begin
            ram[req_idx] <= req_wdata;
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: two responders (2 and 0 wait states) against a word-array reference model.
module tb_data_mem_responder;
    localparam int          WS    = 2;
    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wdata, rdata;
    logic        read_enable, write_enable, mem_done, mem_err, busy;
    logic [31:0] addr0, wdata0, rdata0;
    logic        read_enable0, write_enable0, mem_done0, mem_err0, busy0;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] last_rdata;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS), .BASE_ADDR(BASE), .INIT_FILE("")) u_dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .read_enable(read_enable),
        .write_enable(write_enable), .rdata(rdata), .mem_done(mem_done), .mem_err(mem_err), .busy(busy));

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .BASE_ADDR(BASE), .INIT_FILE("")) u_dut0 (
        .clk(clk), .rst(rst), .addr(addr0), .wdata(wdata0), .read_enable(read_enable0),
        .write_enable(write_enable0), .rdata(rdata0), .mem_done(mem_done0), .mem_err(mem_err0), .busy(busy0));

    function automatic bit exp_err(input bit rd, input bit wr, input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a[1:0] != 2'b00) || ((off >> 2) >= DEPTH) || (rd && wr);
    endfunction

    function automatic int widx(input logic [31:0] a);
        logic [31:0] off;
        off = (a - BASE) >> 2;
        return int'(off);
    endfunction

    // Applies the reference rules of one completed request to the model.
    task automatic model_apply(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        if (exp_err(rd, wr, a)) last_rdata = 32'h0;
        else if (wr)            model[widx(a)] = d;
        else if (rd)            last_rdata = model[widx(a)];
    endtask

    // Issues one request on the WS instance; starts and ends just after a rising edge.
    task automatic do_req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output bit err, output logic [31:0] rv, output bit busy_ok);
        read_enable = rd; write_enable = wr; addr = a; wdata = d;
        lat = -1; err = 1'b0; rv = 32'h0; busy_ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busy !== (k >= 1)) busy_ok = 1'b0;
            if (mem_done === 1'b1) begin
                lat = k; err = mem_err; rv = rdata;
                break;
            end
        end
        @(posedge clk); #1;
        read_enable = 1'b0; write_enable = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        read_enable = 0; write_enable = 0; addr = 0; wdata = 0;
        read_enable0 = 0; write_enable0 = 0; addr0 = 0; wdata0 = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        last_rdata = 32'h0;
        @(negedge clk);
        n_cmp++; if (mem_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", mem_done); end
        n_cmp++; if (mem_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", mem_err); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        n_cmp++; if (mem_done0 !== 1'b0 || busy0 !== 1'b0) begin n_bad++; $display("FAIL reset_ws0: got done=%b busy=%b want 0 0", mem_done0, busy0); end
        @(posedge clk); #1;
    endtask

    task automatic test_fill();
        int lat; bit err, bok; logic [31:0] rv, d;
        for (int i = 0; i < DEPTH; i++) begin
            d = $urandom;
            do_req(1'b0, 1'b1, BASE + 32'(i * 4), d, lat, err, rv, bok);
            model_apply(1'b0, 1'b1, BASE + 32'(i * 4), d);
            n_cmp++; if (lat !== WS + 1 || err !== 1'b0) begin n_bad++; $display("FAIL fill[%0d]: got lat=%0d err=%b want lat=%0d err=0", i, lat, err, WS + 1); end
        end
    endtask

    task automatic test_store_load();
        int lat; bit err, bok; logic [31:0] rv;
        do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, err, rv, bok);
        model_apply(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL store_latency: got %0d want 3", lat); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL store_err: got %b want 0", err); end
        n_cmp++; if (bok !== 1'b1) begin n_bad++; $display("FAIL store_busy: got bad want busy in WAIT/DONE only"); end
        do_req(1'b1, 1'b0, 32'h10, 32'h0, lat, err, rv, bok);
        model_apply(1'b1, 1'b0, 32'h10, 32'h0);
        n_cmp++; if (lat !== 3 || err !== 1'b0) begin n_bad++; $display("FAIL load_done: got lat=%0d err=%b want 3 0", lat, err); end
        n_cmp++; if (rv !== 32'hDEADBEEF) begin n_bad++; $display("FAIL load_rdata: got %h want deadbeef", rv); end
        @(negedge clk);
        n_cmp++; if (rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rdata_hold: got %h want deadbeef", rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_errors();
        int lat; bit err, bok; logic [31:0] rv;
        do_req(1'b1, 1'b0, 32'h12, 32'h0, lat, err, rv, bok);
        model_apply(1'b1, 1'b0, 32'h12, 32'h0);
        n_cmp++; if (lat !== 3 || err !== 1'b1) begin n_bad++; $display("FAIL misaligned_err: got lat=%0d err=%b want 3 1", lat, err); end
        n_cmp++; if (rv !== 32'h0) begin n_bad++; $display("FAIL misaligned_rdata: got %h want 0", rv); end
        do_req(1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, lat, err, rv, bok);
        model_apply(1'b0, 1'b1, 32'h400, 32'hA5A5A5A5);
        n_cmp++; if (lat !== 3 || err !== 1'b1) begin n_bad++; $display("FAIL oor_err: got lat=%0d err=%b want 3 1", lat, err); end
        do_req(1'b1, 1'b0, 32'h0, 32'h0, lat, err, rv, bok);
        n_cmp++; if (rv !== model[0] || err !== 1'b0) begin n_bad++; $display("FAIL oor_unchanged: got %h err=%b want %h 0", rv, err, model[0]); end
        model_apply(1'b1, 1'b0, 32'h0, 32'h0);
        do_req(1'b1, 1'b1, 32'h8, 32'h11112222, lat, err, rv, bok);
        model_apply(1'b1, 1'b1, 32'h8, 32'h11112222);
        n_cmp++; if (err !== 1'b1 || rv !== 32'h0) begin n_bad++; $display("FAIL rdwr_err: got err=%b rdata=%h want 1 0", err, rv); end
        do_req(1'b1, 1'b0, 32'h8, 32'h0, lat, err, rv, bok);
        n_cmp++; if (rv !== model[2]) begin n_bad++; $display("FAIL rdwr_unchanged: got %h want %h", rv, model[2]); end
        model_apply(1'b1, 1'b0, 32'h8, 32'h0);
    endtask

    task automatic test_abort();
        int lat; bit err, bok, seen; logic [31:0] rv;
        write_enable = 1'b1; addr = 32'h20; wdata = 32'h12345678;
        @(posedge clk); #1;
        write_enable = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (mem_done !== 1'b0) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_no_done: got pulse want none"); end
        @(posedge clk); #1;
        do_req(1'b1, 1'b0, 32'h20, 32'h0, lat, err, rv, bok);
        n_cmp++; if (rv !== model[8]) begin n_bad++; $display("FAIL abort_unchanged: got %h want %h", rv, model[8]); end
        model_apply(1'b1, 1'b0, 32'h20, 32'h0);
    endtask

    task automatic test_reset_mid();
        int lat; bit err, bok, seen; logic [31:0] rv;
        write_enable = 1'b1; addr = 32'h24; wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; write_enable = 1'b0;
        last_rdata = 32'h0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL rst_mid_rdata: got %h want 0", rdata); end
        seen = (mem_done !== 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (mem_done !== 1'b0) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rst_mid_no_done: got pulse want none"); end
        @(posedge clk); #1;
        do_req(1'b1, 1'b0, 32'h24, 32'h0, lat, err, rv, bok);
        n_cmp++; if (rv !== model[9]) begin n_bad++; $display("FAIL rst_mid_unchanged: got %h want %h", rv, model[9]); end
        model_apply(1'b1, 1'b0, 32'h24, 32'h0);
    endtask

    task automatic test_random();
        int lat; bit err, bok, rd, wr, e; logic [31:0] rv, a, d, exp_rd;
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 9))
                0:       a = 32'($urandom_range(0, DEPTH - 1) * 4) + 32'($urandom_range(1, 3));
                1:       a = $urandom | 32'h0000_0400;
                default: a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
            endcase
            rd = ($urandom_range(0, 1) == 1);
            wr = !rd || ($urandom_range(0, 15) == 0);
            d  = $urandom;
            e  = exp_err(rd, wr, a);
            model_apply(rd, wr, a, d);
            exp_rd = last_rdata;
            do_req(rd, wr, a, d, lat, err, rv, bok);
            n_cmp++; if (lat !== WS + 1 || bok !== 1'b1) begin n_bad++; $display("FAIL rand_timing[%0d]: got lat=%0d busy_ok=%b want %0d 1", i, lat, bok, WS + 1); end
            n_cmp++; if (err !== e) begin n_bad++; $display("FAIL rand_err[%0d] a=%h: got %b want %b", i, a, err, e); end
            n_cmp++; if (rv !== exp_rd) begin n_bad++; $display("FAIL rand_rdata[%0d] a=%h: got %h want %h", i, a, rv, exp_rd); end
        end
    endtask

    // Requests held continuously on the zero-wait instance; each switches right after its pulse.
    task automatic test_back_to_back();
        bit          rds [6] = '{0, 0, 1, 1, 0, 1};
        logic [31:0] as  [6] = '{32'h0, 32'h4, 32'h0, 32'h4, 32'h8, 32'h8};
        logic [31:0] ds  [6] = '{32'h0BAD_F00D, 32'h5555_AAAA, 32'h0, 32'h0, 32'h7777_1234, 32'h0};
        logic [31:0] exp [6] = '{32'h0, 32'h0, 32'h0BAD_F00D, 32'h5555_AAAA, 32'h5555_AAAA, 32'h7777_1234};
        for (int i = 0; i < 6; i++) begin
            read_enable0 = rds[i]; write_enable0 = !rds[i]; addr0 = as[i]; wdata0 = ds[i];
            @(negedge clk);
            n_cmp++; if (mem_done0 !== 1'b0) begin n_bad++; $display("FAIL b2b_gap[%0d]: got %b want 0", i, mem_done0); end
            @(posedge clk); #1;
            @(negedge clk);
            n_cmp++; if (mem_done0 !== 1'b1 || mem_err0 !== 1'b0) begin n_bad++; $display("FAIL b2b_done[%0d]: got done=%b err=%b want 1 0", i, mem_done0, mem_err0); end
            n_cmp++; if (rdata0 !== exp[i]) begin n_bad++; $display("FAIL b2b_rdata[%0d]: got %h want %h", i, rdata0, exp[i]); end
            @(posedge clk); #1;
        end
        read_enable0 = 1'b0; write_enable0 = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_store_load();
        test_errors();
        test_abort();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
